// File: rtl/morse_key_capture.sv
// rtl/morse_key_capture.sv - straight-key morse capture: dot/dash timing, symbol buffer, commit
module morse_key_capture #(
    parameter int MAX_LEN    = 5,
    parameter int LEN_W      = 3,
    parameter int DASH_TICKS = 3,
    parameter int GAP_TICKS  = 7,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               key,
    input  logic               btn_enter,
    input  logic               btn_back,
    input  logic               btn_clear,
    output logic [MAX_LEN-1:0] morse_code,
    output logic [LEN_W-1:0]   morse_len,
    output logic               decode_valid,
    output logic               overflow,
    output logic               key_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [MAX_LEN-1:0] ONE      = MAX_LEN'(1);
    localparam logic [LEN_W-1:0]   FULL_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LAST_POS = LEN_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0]   DASH_CNT = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0]   GAP_CNT  = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    state_t             state_q;
    logic [CNT_W-1:0]   press_cnt_q;
    logic [CNT_W-1:0]   gap_cnt_q;
    logic [MAX_LEN-1:0] code_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;
    logic               valid_q;
    logic               key_prev_q;
    logic               enter_prev_q;
    logic               back_prev_q;
    logic               clear_prev_q;

    logic key_rise_d, key_fall_d, enter_rise_d, back_rise_d, clear_rise_d;
    logic has_sym_d, dash_d, gap_done_d;

    assign key_rise_d   = key & ~key_prev_q;
    assign key_fall_d   = ~key & key_prev_q;
    assign enter_rise_d = btn_enter & ~enter_prev_q;
    assign back_rise_d  = btn_back & ~back_prev_q;
    assign clear_rise_d = btn_clear & ~clear_prev_q;
    assign has_sym_d    = (len_q != '0);
    assign dash_d       = (press_cnt_q >= DASH_CNT);
    // Timeout fires on the tick that brings gap_cnt up to GAP_TICKS.
    assign gap_done_d   = (GAP_TICKS != 0) && tick && ((gap_cnt_q + CNT_W'(1)) >= GAP_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            press_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            code_q       <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
            key_prev_q   <= 1'b0;
            enter_prev_q <= 1'b0;
            back_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            key_prev_q   <= key;
            enter_prev_q <= btn_enter;
            back_prev_q  <= btn_back;
            clear_prev_q <= btn_clear;

            // Clear and the post-commit cycle share the same wipe; neither pulses.
            if (clear_rise_d || valid_q) begin
                state_q     <= S_IDLE;
                press_cnt_q <= '0;
                gap_cnt_q   <= '0;
                code_q      <= '0;
                len_q       <= '0;
                ovf_q       <= 1'b0;
                valid_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (enter_rise_d && has_sym_d) begin
                            valid_q <= 1'b1;
                        end else if (back_rise_d && has_sym_d) begin
                            code_q    <= code_q & ~(ONE << (FULL_LEN - len_q));
                            len_q     <= len_q - LEN_W'(1);
                            gap_cnt_q <= '0;
                        end else if (key_rise_d) begin
                            state_q     <= S_PRESS;
                            press_cnt_q <= '0;
                        end
                    end
                    S_PRESS: begin
                        if (key_fall_d) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                            if (len_q < FULL_LEN) begin
                                if (dash_d) begin
                                    code_q <= code_q | (ONE << (LAST_POS - len_q));
                                end
                                len_q <= len_q + LEN_W'(1);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else if (tick && (press_cnt_q < DASH_CNT)) begin
                            press_cnt_q <= press_cnt_q + CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (enter_rise_d && has_sym_d) begin
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (gap_done_d) begin
                            // An empty buffer at timeout just drops back to idle.
                            valid_q   <= has_sym_d;
                            state_q   <= S_IDLE;
                            gap_cnt_q <= '0;
                        end else if (back_rise_d && has_sym_d) begin
                            code_q    <= code_q & ~(ONE << (FULL_LEN - len_q));
                            len_q     <= len_q - LEN_W'(1);
                            gap_cnt_q <= '0;
                        end else if (key_rise_d) begin
                            state_q     <= S_PRESS;
                            press_cnt_q <= '0;
                            gap_cnt_q   <= '0;
                        end else if (tick && (gap_cnt_q != CNT_MAX)) begin
                            gap_cnt_q <= gap_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign morse_code   = code_q;
    assign morse_len    = len_q;
    assign decode_valid = valid_q;
    assign overflow     = ovf_q;
    assign key_active   = (state_q == S_PRESS);

endmodule

// File: tb/tb_morse_key_capture.sv
// tb/tb_morse_key_capture.sv - directed bench for morse_key_capture
module tb_morse_key_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       key = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_back = 1'b0;
    logic       btn_clear = 1'b0;

    logic [4:0] morse_code;
    logic [2:0] morse_len;
    logic       decode_valid;
    logic       overflow;
    logic       key_active;

    logic [4:0] code0;
    logic [2:0] len0;
    logic       valid0;
    logic       ovf0;
    logic       active0;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses0;

    always #5 clk = ~clk;

    morse_key_capture #(.MAX_LEN(5), .LEN_W(3), .DASH_TICKS(3), .GAP_TICKS(7), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .key(key),
        .btn_enter(btn_enter), .btn_back(btn_back), .btn_clear(btn_clear),
        .morse_code(morse_code), .morse_len(morse_len), .decode_valid(decode_valid),
        .overflow(overflow), .key_active(key_active)
    );

    morse_key_capture #(.MAX_LEN(5), .LEN_W(3), .DASH_TICKS(3), .GAP_TICKS(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .key(key),
        .btn_enter(btn_enter), .btn_back(btn_back), .btn_clear(btn_clear),
        .morse_code(code0), .morse_len(len0), .decode_valid(valid0),
        .overflow(ovf0), .key_active(active0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic press(input int nticks);
        key = 1'b1;
        cyc(1);
        for (int i = 0; i < nticks; i++) do_tick();
        key = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_clear();
        btn_clear = 1'b1;
        cyc(1);
        btn_clear = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_back();
        btn_back = 1'b1;
        cyc(1);
        btn_back = 1'b0;
        cyc(1);
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_code", morse_code, 5'b00000);
        chk("rst_len", morse_len, 3'd0);
        chk("rst_valid", decode_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_active", key_active, 1'b0);
        rst = 1'b0;
        cyc(2);

        // Dot then dash, enter
        press(1);
        press(4);
        chk("t1_pre_len", morse_len, 3'd2);
        btn_enter = 1'b1;
        cyc(1);
        chk("t1_valid", decode_valid, 1'b1);
        chk("t1_code", morse_code, 5'b01000);
        chk("t1_len", morse_len, 3'd2);
        btn_enter = 1'b0;
        cyc(1);
        chk("t1_valid_after", decode_valid, 1'b0);
        chk("t1_code_after", morse_code, 5'b00000);
        chk("t1_len_after", morse_len, 3'd0);

        // Six dots overflow, enter
        for (int i = 0; i < 6; i++) press(0);
        btn_enter = 1'b1;
        cyc(1);
        chk("t2_valid", decode_valid, 1'b1);
        chk("t2_len", morse_len, 3'd5);
        chk("t2_code", morse_code, 5'b00000);
        chk("t2_ovf", overflow, 1'b1);
        btn_enter = 1'b0;
        cyc(1);
        chk("t2_ovf_after", overflow, 1'b0);
        chk("t2_len_after", morse_len, 3'd0);

        // Gap timeout with GAP_TICKS=7; GAP_TICKS=0 instance never commits
        pulse_clear();
        press(3);
        chk("t3_key_idle", key_active, 1'b0);
        for (int i = 0; i < 6; i++) do_tick();
        chk("t3_no_early", decode_valid, 1'b0);
        do_tick();
        chk("t3_valid", decode_valid, 1'b1);
        chk("t3_code", morse_code, 5'b10000);
        chk("t3_len", morse_len, 3'd1);
        cyc(1);
        chk("t3_valid_after", decode_valid, 1'b0);
        pulses0 = 0;
        for (int i = 0; i < 100; i++) begin
            do_tick();
            if (valid0) pulses0++;
        end
        chk("t3_gap0_pulses", pulses0, 0);
        chk("t3_gap0_len", len0, 3'd1);
        chk("t3_gap0_code", code0, 5'b10000);

        // Backspace
        pulse_clear();
        press(3);
        press(3);
        press(0);
        chk("t4_code3", morse_code, 5'b11000);
        chk("t4_len3", morse_len, 3'd3);
        pulse_back();
        chk("t4_code2", morse_code, 5'b11000);
        chk("t4_len2", morse_len, 3'd2);
        pulse_back();
        chk("t4_code1", morse_code, 5'b10000);
        chk("t4_len1", morse_len, 3'd1);
        pulse_back();
        chk("t4_len0", morse_len, 3'd0);
        chk("t4_code0", morse_code, 5'b00000);
        pulse_back();
        chk("t4_len0_again", morse_len, 3'd0);
        btn_enter = 1'b1;
        cyc(1);
        chk("t4_enter_empty", decode_valid, 1'b0);
        btn_enter = 1'b0;
        cyc(1);
        chk("t4_enter_empty2", decode_valid, 1'b0);

        // Key fall and enter rise together; clear during decode_valid
        pulse_clear();
        press(3);
        key = 1'b1;
        cyc(1);
        chk("t5_active", key_active, 1'b1);
        key = 1'b0;
        btn_enter = 1'b1;
        cyc(1);
        chk("t5_no_commit", decode_valid, 1'b0);
        chk("t5_len", morse_len, 3'd2);
        chk("t5_code", morse_code, 5'b10000);
        btn_enter = 1'b0;
        cyc(1);
        chk("t5_no_commit2", decode_valid, 1'b0);
        btn_enter = 1'b1;
        cyc(1);
        chk("t5_valid", decode_valid, 1'b1);
        btn_enter = 1'b0;
        btn_clear = 1'b1;
        cyc(1);
        chk("t5_clr_valid", decode_valid, 1'b0);
        chk("t5_clr_len", morse_len, 3'd0);
        chk("t5_clr_code", morse_code, 5'b00000);
        btn_clear = 1'b0;
        cyc(1);
        chk("t5_no_second", decode_valid, 1'b0);

        // Async reset mid-press
        press(3);
        key = 1'b1;
        cyc(1);
        do_tick();
        do_tick();
        chk("t6_active", key_active, 1'b1);
        chk("t6_len_before", morse_len, 3'd1);
        rst = 1'b1;
        #2;
        chk("t6_rst_active", key_active, 1'b0);
        chk("t6_rst_len", morse_len, 3'd0);
        chk("t6_rst_code", morse_code, 5'b00000);
        key = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        press(4);
        btn_enter = 1'b1;
        cyc(1);
        chk("t6_valid", decode_valid, 1'b1);
        chk("t6_code", morse_code, 5'b10000);
        chk("t6_len", morse_len, 3'd1);
        btn_enter = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
